// File: rtl/multi_cam_capture.sv
// multi_cam_capture
//   NUM_CAMS independent camera capture channels on one pixel clock. Each
//   channel synchronises its raw camera bus, assembles 16-bit pixels from
//   byte pairs, optionally converts them to 8-bit greyscale, and drives a
//   frame-buffer write port. Freeze and greyscale selection are latched at
//   frame boundaries. Malformed lines and frames set a sticky error flag.
//   A pairing pulse fires once every channel has completed a frame.
//
// Ports
//   clk_pixel_in     pixel clock (only clock)
//   rst_in           synchronous active-high reset
//   cam_data_in      raw bytes, channel k at [8k+7:8k]
//   cam_sync_in      raw sync, channel k: [3k]=pclk [3k+1]=vsync [3k+2]=href
//   freeze_in        per-channel freeze request (sampled at frame boundary)
//   gray_mode_in     0 = RGB565, 1 = greyscale (sampled at frame boundary)
//   wr_addr_out      per-channel buffer write address
//   wr_data_out      per-channel buffer write data
//   wr_en_out        per-channel single-cycle write strobe
//   frame_done_out   per-channel single-cycle end-of-frame pulse
//   frame_count_out  per-channel wrapping completed-frame counter
//   frozen_out       per-channel latched freeze state
//   frame_err_out    per-channel sticky malformed-frame flag
//   pair_ready_out   pulse when all channels have completed a frame
module multi_cam_capture #(
  parameter int NUM_CAMS    = 2,
  parameter int H_PIXELS    = 320,
  parameter int V_PIXELS    = 240,
  parameter int ADDR_WIDTH  = 17,
  parameter int SYNC_STAGES = 2,
  parameter int FC_WIDTH    = 6
) (
  input  logic                             clk_pixel_in,
  input  logic                             rst_in,
  input  logic [NUM_CAMS*8-1:0]            cam_data_in,
  input  logic [NUM_CAMS*3-1:0]            cam_sync_in,
  input  logic [NUM_CAMS-1:0]              freeze_in,
  input  logic                             gray_mode_in,
  output logic [NUM_CAMS*ADDR_WIDTH-1:0]   wr_addr_out,
  output logic [NUM_CAMS*16-1:0]           wr_data_out,
  output logic [NUM_CAMS-1:0]              wr_en_out,
  output logic [NUM_CAMS-1:0]              frame_done_out,
  output logic [NUM_CAMS*FC_WIDTH-1:0]     frame_count_out,
  output logic [NUM_CAMS-1:0]              frozen_out,
  output logic [NUM_CAMS-1:0]              frame_err_out,
  output logic                             pair_ready_out
);

  typedef enum logic [1:0] {
    WAIT_VSYNC,
    LINE_IDLE,
    BYTE_HI,
    BYTE_LO
  } chan_state_t;

  localparam logic [10:0] H_LIM = 11'(H_PIXELS);
  localparam logic [9:0]  V_LIM = 10'(V_PIXELS);

  // Y = (77*R8 + 150*G8 + 29*B8) >> 8 on a 16-bit intermediate.
  function automatic logic [7:0] to_gray(input logic [15:0] px);
    logic [15:0] r8, g8, b8, y;
    r8 = {8'h00, px[15:11], 3'b000};
    g8 = {8'h00, px[10:5], 2'b00};
    b8 = {8'h00, px[4:0], 3'b000};
    y  = 16'd77 * r8 + 16'd150 * g8 + 16'd29 * b8;
    return 8'(y >> 8);
  endfunction

  logic [NUM_CAMS-1:0] frame_done_v;
  logic [NUM_CAMS-1:0] pending;
  logic                pair_all;

  for (genvar k = 0; k < NUM_CAMS; k++) begin : g_chan
    logic [SYNC_STAGES-1:0][10:0] sync_q;
    logic [10:0]                  raw;
    logic [2:0]                   ctl_d;
    logic [7:0]                   byte_s;
    logic                         pclk_s, vsync_s, href_s;
    logic                         pclk_rise, vsync_rise, href_fall;

    chan_state_t           state;
    logic [10:0]           hcount;
    logic [9:0]            vcount;
    logic [7:0]            hi_byte;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [15:0]           wr_data_q;
    logic                  frame_done_q;
    logic [FC_WIDTH-1:0]   frame_count_q;
    logic                  frozen_q;
    logic                  gray_q;
    logic                  err_q;

    assign raw = {cam_sync_in[3*k +: 3], cam_data_in[8*k +: 8]};

    always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
        sync_q <= '0;
        ctl_d  <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        ctl_d  <= sync_q[SYNC_STAGES-1][10:8];
      end
    end

    assign byte_s     = sync_q[SYNC_STAGES-1][7:0];
    assign pclk_s     = sync_q[SYNC_STAGES-1][8];
    assign vsync_s    = sync_q[SYNC_STAGES-1][9];
    assign href_s     = sync_q[SYNC_STAGES-1][10];
    assign pclk_rise  = pclk_s & ~ctl_d[0];
    assign vsync_rise = vsync_s & ~ctl_d[1];
    assign href_fall  = ~href_s & ctl_d[2];

    always_ff @(posedge clk_pixel_in) begin
      if (rst_in) begin
        state         <= WAIT_VSYNC;
        hcount        <= '0;
        vcount        <= '0;
        hi_byte       <= '0;
        wr_en_q       <= 1'b0;
        wr_addr_q     <= '0;
        wr_data_q     <= '0;
        frame_done_q  <= 1'b0;
        frame_count_q <= '0;
        frozen_q      <= 1'b0;
        gray_q        <= 1'b0;
        err_q         <= 1'b0;
      end else begin
        wr_en_q      <= 1'b0;
        frame_done_q <= 1'b0;
        if (state == WAIT_VSYNC) begin
          if (vsync_rise) begin
            state    <= LINE_IDLE;
            frozen_q <= freeze_in[k];
            gray_q   <= gray_mode_in;
          end
        end else if (vsync_rise) begin
          if (vcount != V_LIM) err_q <= 1'b1;
          frame_done_q  <= 1'b1;
          frame_count_q <= frame_count_q + FC_WIDTH'(1);
          hcount        <= '0;
          vcount        <= '0;
          frozen_q      <= freeze_in[k];
          gray_q        <= gray_mode_in;
          state         <= LINE_IDLE;
        end else if (href_fall && (state == BYTE_HI || state == BYTE_LO)) begin
          // A half pixel left in BYTE_LO is simply dropped here.
          if (hcount != '0 && vcount != '1) vcount <= vcount + 10'd1;
          if (hcount != H_LIM) err_q <= 1'b1;
          hcount <= '0;
          state  <= LINE_IDLE;
        end else if (pclk_rise && href_s) begin
          case (state)
            // The edge that opens a line already carries the upper byte,
            // so LINE_IDLE captures it exactly as BYTE_HI would.
            LINE_IDLE, BYTE_HI: begin
              hi_byte <= byte_s;
              state   <= BYTE_LO;
            end
            BYTE_LO: begin
              if (hcount < H_LIM && vcount < V_LIM && !frozen_q) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= ADDR_WIDTH'(32'(vcount) * 32'(H_PIXELS) + 32'(hcount));
                wr_data_q <= gray_q ? {8'h00, to_gray({hi_byte, byte_s})}
                                    : {hi_byte, byte_s};
              end
              if (hcount != '1) hcount <= hcount + 11'd1;
              state <= BYTE_HI;
            end
            default: ;
          endcase
        end
      end
    end

    assign wr_en_out[k]                             = wr_en_q;
    assign wr_addr_out[k*ADDR_WIDTH +: ADDR_WIDTH]  = wr_addr_q;
    assign wr_data_out[k*16 +: 16]                  = wr_data_q;
    assign frame_done_out[k]                        = frame_done_q;
    assign frame_done_v[k]                          = frame_done_q;
    assign frame_count_out[k*FC_WIDTH +: FC_WIDTH]  = frame_count_q;
    assign frozen_out[k]                            = frozen_q;
    assign frame_err_out[k]                         = err_q;
  end

  // A done arriving in the pairing cycle is consumed by that pulse.
  assign pair_all       = &(pending | frame_done_v);
  assign pair_ready_out = pair_all;

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      pending <= '0;
    end else if (pair_all) begin
      pending <= '0;
    end else begin
      pending <= pending | frame_done_v;
    end
  end

endmodule

// File: tb/tb_multi_cam_capture.sv
module tb_multi_cam_capture;
  localparam int NC  = 2;
  localparam int HP  = 16;
  localparam int VP  = 12;
  localparam int AW  = 8;
  localparam int SS  = 2;
  localparam int FCW = 3;
  localparam int NV  = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [NC*8-1:0]     cam_data_in;
  logic [NC*3-1:0]     cam_sync_in;
  logic [NC-1:0]       freeze;
  logic                gray;
  logic [NC*AW-1:0]    wr_addr_out;
  logic [NC*16-1:0]    wr_data_out;
  logic [NC-1:0]       wr_en_out;
  logic [NC-1:0]       frame_done_out;
  logic [NC*FCW-1:0]   frame_count_out;
  logic [NC-1:0]       frozen_out;
  logic [NC-1:0]       frame_err_out;
  logic                pair_ready_out;

  multi_cam_capture #(
    .NUM_CAMS(NC), .H_PIXELS(HP), .V_PIXELS(VP),
    .ADDR_WIDTH(AW), .SYNC_STAGES(SS), .FC_WIDTH(FCW)
  ) dut (
    .clk_pixel_in(clk), .rst_in(rst),
    .cam_data_in(cam_data_in), .cam_sync_in(cam_sync_in),
    .freeze_in(freeze), .gray_mode_in(gray),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out), .wr_en_out(wr_en_out),
    .frame_done_out(frame_done_out), .frame_count_out(frame_count_out),
    .frozen_out(frozen_out), .frame_err_out(frame_err_out),
    .pair_ready_out(pair_ready_out)
  );

  logic [7:0] cam_d    [NC];
  logic       cam_pclk [NC];
  logic       cam_vs   [NC];
  logic       cam_hr   [NC];

  always_comb begin
    cam_data_in = '0;
    cam_sync_in = '0;
    for (int k = 0; k < NC; k++) begin
      cam_data_in[8*k +: 8] = cam_d[k];
      cam_sync_in[3*k]      = cam_pclk[k];
      cam_sync_in[3*k+1]    = cam_vs[k];
      cam_sync_in[3*k+2]    = cam_hr[k];
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            cyc;
  } sb_t;

  typedef struct {
    logic [15:0] px;
    logic [15:0] y;
  } gvec_t;

  sb_t         exp_q [NC][$];
  sb_t         mon_e;
  gvec_t       tbl   [NV];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          fd_cnt [NC];
  int          pair_cnt = 0;
  logic [NC-1:0] pair_fd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: sampled on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (frame_done_out[k]) fd_cnt[k]++;
      if (wr_en_out[k]) begin
        checks++;
        if (exp_q[k].size() == 0) begin
          errors++;
          $display("FAIL unexpected_write cam%0d: got addr %0d data %h at cycle %0d, required no write",
                   k, wr_addr_out[k*AW +: AW], wr_data_out[k*16 +: 16], cyc);
        end else begin
          mon_e = exp_q[k].pop_front();
          if (wr_addr_out[k*AW +: AW] !== mon_e.addr || wr_data_out[k*16 +: 16] !== mon_e.data
              || cyc != mon_e.cyc) begin
            errors++;
            $display("FAIL write cam%0d: got addr %0d data %h cycle %0d, required addr %0d data %h cycle %0d",
                     k, wr_addr_out[k*AW +: AW], wr_data_out[k*16 +: 16], cyc,
                     mon_e.addr, mon_e.data, mon_e.cyc);
          end
        end
      end
    end
    if (pair_ready_out) begin
      pair_cnt++;
      pair_fd = frame_done_out;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drain(input string name, input int k);
    repeat (8) @(negedge clk);
    check(name, 64'(exp_q[k].size()), 64'd0);
  endtask

  task automatic send_byte(input int k, input logic [7:0] b, output int rise_cyc);
    @(negedge clk);
    cam_d[k]    = b;
    cam_pclk[k] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cam_pclk[k] = 1'b1;
    rise_cyc    = cyc;
    @(negedge clk);
  endtask

  // Write expected SS sync cycles plus one register after the raw lo edge.
  task automatic send_pixel(input int k, input logic [15:0] px, input bit push,
                            input logic [AW-1:0] addr, input logic [15:0] exp_data);
    int rc;
    send_byte(k, px[15:8], rc);
    send_byte(k, px[7:0], rc);
    if (push) exp_q[k].push_back('{addr, exp_data, rc + SS + 1});
  endtask

  task automatic line_start(input int k);
    @(negedge clk);
    cam_hr[k] = 1'b1;
  endtask

  task automatic line_end(input int k);
    @(negedge clk);
    cam_hr[k]   = 1'b0;
    cam_pclk[k] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_line(input int k, input int line, input int npix, input bit wr_ok);
    logic [15:0] px;
    line_start(k);
    for (int p = 0; p < npix; p++) begin
      px = 16'($urandom_range(0, 65535));
      send_pixel(k, px, wr_ok && p < HP && line < VP, AW'(line * HP + p), px);
    end
    line_end(k);
  endtask

  task automatic vsync_pulse(input int k);
    @(negedge clk);
    cam_vs[k] = 1'b1;
    repeat (4) @(negedge clk);
    cam_vs[k] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #5ms;
    errors++;
    $display("FAIL timeout: got no end of test, required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int rc;
    tbl[0] = '{16'hFFFF, 16'h00FA};
    tbl[1] = '{16'hF800, 16'h004A};
    tbl[2] = '{16'h07E0, 16'h0093};
    tbl[3] = '{16'h001F, 16'h001C};
    tbl[4] = '{16'h8410, 16'h0080};
    tbl[5] = '{16'h1234, 16'h003E};
    tbl[6] = '{16'h0000, 16'h0000};
    rst = 1'b1; freeze = '0; gray = 1'b0;
    for (int k = 0; k < NC; k++) begin
      cam_d[k] = '0; cam_pclk[k] = 1'b0; cam_vs[k] = 1'b0; cam_hr[k] = 1'b0; fd_cnt[k] = 0;
    end
    repeat (3) @(negedge clk);
    check("reset_wr", 64'({wr_addr_out, wr_data_out}), 64'd0);
    check("reset_ctl", 64'({wr_en_out, frame_done_out, frame_count_out, frozen_out,
                            frame_err_out, pair_ready_out}), 64'd0);
    rst = 1'b0;

    // Bytes before the first vsync are ignored.
    send_line(0, 0, 4, 1'b0);

    // Frame A: RGB, full frame.
    vsync_pulse(0);
    for (int l = 0; l < VP; l++) send_line(0, l, HP, 1'b1);
    gray = 1'b1;
    vsync_pulse(0);
    drain("frameA_writes", 0);
    check("frameA_done_pulses", 64'(fd_cnt[0]), 64'd1);
    check("frameA_count", 64'(frame_count_out[FCW-1:0]), 64'd1);
    check("frameA_err", 64'(frame_err_out[0]), 64'd0);

    // Greyscale frame driven from the vector table.
    for (int l = 0; l < VP; l++) begin
      line_start(0);
      for (int p = 0; p < HP; p++)
        send_pixel(0, tbl[(l*HP+p) % NV].px, 1'b1, AW'(l*HP+p), tbl[(l*HP+p) % NV].y);
      line_end(0);
    end
    gray = 1'b0;
    vsync_pulse(0);
    drain("gray_writes", 0);
    check("gray_count", 64'(frame_count_out[FCW-1:0]), 64'd2);
    check("gray_err", 64'(frame_err_out[0]), 64'd0);

    // Oversized lines and frame: only in-range pixels written, error set.
    for (int l = 0; l < VP + 1; l++) send_line(0, l, HP + 2, 1'b1);
    vsync_pulse(0);
    drain("oversize_writes", 0);
    check("oversize_err", 64'(frame_err_out[0]), 64'd1);
    check("oversize_count", 64'(frame_count_out[FCW-1:0]), 64'd3);

    // Good frame afterwards: error stays sticky.
    for (int l = 0; l < VP; l++) send_line(0, l, HP, 1'b1);
    vsync_pulse(0);
    drain("frameD_writes", 0);
    check("sticky_err", 64'(frame_err_out[0]), 64'd1);
    check("no_pair_yet", 64'(pair_cnt), 64'd0);

    // cam1: freeze raised mid-frame; this frame still fully written.
    vsync_pulse(1);
    for (int l = 0; l < VP; l++) begin
      if (l == 5) freeze[1] = 1'b1;
      send_line(1, l, HP, 1'b1);
    end
    vsync_pulse(1);
    drain("freeze_frame_writes", 1);
    check("pair_after_cam1", 64'(pair_cnt), 64'd1);
    check("pair_with_cam1_done", 64'(pair_fd), 64'b10);
    check("frozen_latched", 64'(frozen_out), 64'b10);

    // Frozen frame: no writes, but done still pulses.
    for (int l = 0; l < VP; l++) send_line(1, l, HP, 1'b0);
    vsync_pulse(1);
    freeze[1] = 1'b0;
    drain("frozen_no_writes", 1);
    check("frozen_done_pulses", 64'(fd_cnt[1]), 64'd2);
    check("frozen_count", 64'(frame_count_out[2*FCW-1:FCW]), 64'd2);
    check("frozen_held", 64'(frozen_out[1]), 64'd1);
    check("pair_not_repeated", 64'(pair_cnt), 64'd1);

    vsync_pulse(0);
    check("pair_second", 64'(pair_cnt), 64'd2);
    check("pair_second_done", 64'(pair_fd), 64'b01);

    fork
      vsync_pulse(0);
      vsync_pulse(1);
    join
    check("pair_simultaneous", 64'(pair_cnt), 64'd3);
    check("pair_simul_dones", 64'(pair_fd), 64'b11);
    check("freeze_released", 64'(frozen_out[1]), 64'd0);

    // Counter wrap: 6 frames so far on cam0, three more -> 9 mod 8.
    repeat (3) vsync_pulse(0);
    check("count_wrap", 64'(frame_count_out[FCW-1:0]), 64'd1);

    // Reset mid-line.
    vsync_pulse(0);
    line_start(0);
    for (int p = 0; p < 5; p++) send_pixel(0, 16'(16'hA500 + p), 1'b1, AW'(p), 16'(16'hA500 + p));
    send_byte(0, 8'hAB, rc);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_wr", 64'({wr_addr_out, wr_data_out}), 64'd0);
    check("midreset_ctl", 64'({wr_en_out, frame_done_out, frame_count_out, frozen_out,
                               frame_err_out, pair_ready_out}), 64'd0);
    cam_hr[0] = 1'b0; cam_pclk[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_line(0, 0, HP, 1'b0);
    vsync_pulse(0);
    send_line(0, 0, HP, 1'b1);
    drain("post_reset_writes", 0);
    check("post_reset_done", 64'(frame_done_out), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
